// File: rtl/mc_ctrl.sv
// Moore FSM controller for the multi-cycle MIPS core (lw, sw, R-type, beq, addi, slti, j, jal, jr).
// Optional performance counters are built when MC_CTRL_PERF_EN is defined.
module mc_ctrl #(
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        opcode,
    input  logic [5:0]        funct,
    input  logic              zero,
    output logic              pc_write,
    output logic              pc_write_cond,
    output logic              i_or_d,
    output logic              mem_read,
    output logic              mem_write,
    output logic              ir_write,
    output logic              reg_dst,
    output logic              reg_dst2,
    output logic              data_write,
    output logic              mem_to_reg,
    output logic              reg_write,
    output logic              alu_src_a,
    output logic [1:0]        alu_src_b,
    output logic [2:0]        alu_ctrl,
    output logic [1:0]        pc_src,
    output logic              illegal,
`ifdef MC_CTRL_PERF_EN
    output logic [PERF_W-1:0] instr_count,
    output logic [PERF_W-1:0] cycle_count,
`endif
    output logic [3:0]        state
);
    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEM_ADR = 4'd2;
    localparam logic [3:0] S_MEM_RD  = 4'd3;
    localparam logic [3:0] S_MEM_WB  = 4'd4;
    localparam logic [3:0] S_MEM_WR  = 4'd5;
    localparam logic [3:0] S_R_EX    = 4'd6;
    localparam logic [3:0] S_R_WB    = 4'd7;
    localparam logic [3:0] S_BEQ     = 4'd8;
    localparam logic [3:0] S_I_EX    = 4'd9;
    localparam logic [3:0] S_I_WB    = 4'd10;
    localparam logic [3:0] S_JUMP    = 4'd11;
    localparam logic [3:0] S_JAL     = 4'd12;
    localparam logic [3:0] S_JR      = 4'd13;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Returns {supported, alu_ctrl} for an R-type funct field.
    function automatic logic [3:0] alu_decode(input logic [5:0] f);
        case (f)
            6'b100000: alu_decode = {1'b1, ALU_ADD};
            6'b100010: alu_decode = {1'b1, ALU_SUB};
            6'b100100: alu_decode = {1'b1, ALU_AND};
            6'b100101: alu_decode = {1'b1, ALU_OR};
            6'b101010: alu_decode = {1'b1, ALU_SLT};
            default:   alu_decode = {1'b0, ALU_ADD};
        endcase
    endfunction

    logic [3:0] r_state;
    logic       r_illegal;
    logic [3:0] w_next;
    logic       w_ill_next;
    logic [3:0] w_funct_dec;
    logic       w_unused;

    // zero is consumed by the datapath's PC-write gating, not by this FSM.
    assign w_unused    = zero;
    assign w_funct_dec = alu_decode(funct);

    // Next-state selection and illegal-instruction detection.
    always_comb begin
        w_next     = S_FETCH;
        w_ill_next = 1'b0;
        case (r_state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:     w_next = S_MEM_ADR;
                    OP_RTYPE:         w_next = (funct == FN_JR) ? S_JR : S_R_EX;
                    OP_BEQ:           w_next = S_BEQ;
                    OP_ADDI, OP_SLTI: w_next = S_I_EX;
                    OP_J:             w_next = S_JUMP;
                    OP_JAL:           w_next = S_JAL;
                    default: begin
                        w_next     = S_FETCH;
                        w_ill_next = 1'b1;
                    end
                endcase
            end
            S_MEM_ADR: w_next = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:  w_next = S_MEM_WB;
            S_R_EX: begin
                w_next     = w_funct_dec[3] ? S_R_WB : S_FETCH;
                w_ill_next = ~w_funct_dec[3];
            end
            S_I_EX:    w_next = S_I_WB;
            default:   w_next = S_FETCH;
        endcase
    end

    // State register and one-cycle illegal pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_illegal <= w_ill_next;
        end
    end

    logic       w_pc_write, w_pc_write_cond, w_mem_read, w_mem_write, w_ir_write, w_reg_write;
    logic       w_i_or_d, w_reg_dst, w_reg_dst2, w_data_write, w_mem_to_reg, w_alu_src_a;
    logic [1:0] w_alu_src_b, w_pc_src;
    logic [2:0] w_alu_ctrl;

    // Moore output decode from the current state.
    always_comb begin
        w_pc_write = 1'b0; w_pc_write_cond = 1'b0; w_mem_read = 1'b0; w_mem_write = 1'b0;
        w_ir_write = 1'b0; w_reg_write = 1'b0; w_i_or_d = 1'b0; w_reg_dst = 1'b0;
        w_reg_dst2 = 1'b0; w_data_write = 1'b0; w_mem_to_reg = 1'b0; w_alu_src_a = 1'b0;
        w_alu_src_b = 2'b00; w_pc_src = 2'b00; w_alu_ctrl = ALU_ADD;
        case (r_state)
            S_FETCH: begin
                w_mem_read = 1'b1; w_ir_write = 1'b1; w_alu_src_b = 2'b01; w_pc_write = 1'b1;
            end
            S_DECODE:  w_alu_src_b = 2'b11;
            S_MEM_ADR: begin w_alu_src_a = 1'b1; w_alu_src_b = 2'b10; end
            S_MEM_RD:  begin w_mem_read = 1'b1; w_i_or_d = 1'b1; end
            S_MEM_WB:  begin w_reg_write = 1'b1; w_mem_to_reg = 1'b1; end
            S_MEM_WR:  begin w_mem_write = 1'b1; w_i_or_d = 1'b1; end
            S_R_EX:    begin w_alu_src_a = 1'b1; w_alu_ctrl = w_funct_dec[2:0]; end
            S_R_WB:    begin w_reg_write = 1'b1; w_reg_dst = 1'b1; end
            S_BEQ: begin
                w_alu_src_a = 1'b1; w_alu_ctrl = ALU_SUB; w_pc_write_cond = 1'b1; w_pc_src = 2'b01;
            end
            S_I_EX: begin
                w_alu_src_a = 1'b1; w_alu_src_b = 2'b10;
                w_alu_ctrl  = (opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
            end
            S_I_WB:    w_reg_write = 1'b1;
            S_JUMP:    begin w_pc_src = 2'b10; w_pc_write = 1'b1; end
            S_JAL: begin
                w_reg_dst2 = 1'b1; w_data_write = 1'b1; w_reg_write = 1'b1;
                w_pc_src = 2'b10; w_pc_write = 1'b1;
            end
            S_JR:      begin w_pc_src = 2'b11; w_pc_write = 1'b1; end
            default:   w_alu_ctrl = ALU_ADD;
        endcase
    end

    // Architectural-state enables are suppressed for as long as reset is held.
    assign pc_write      = w_pc_write      & ~rst;
    assign pc_write_cond = w_pc_write_cond & ~rst;
    assign mem_read      = w_mem_read      & ~rst;
    assign mem_write     = w_mem_write     & ~rst;
    assign ir_write      = w_ir_write      & ~rst;
    assign reg_write     = w_reg_write     & ~rst;
    assign i_or_d        = w_i_or_d;
    assign reg_dst       = w_reg_dst;
    assign reg_dst2      = w_reg_dst2;
    assign data_write    = w_data_write;
    assign mem_to_reg    = w_mem_to_reg;
    assign alu_src_a     = w_alu_src_a;
    assign alu_src_b     = w_alu_src_b;
    assign alu_ctrl      = w_alu_ctrl;
    assign pc_src        = w_pc_src;
    assign illegal       = r_illegal;
    assign state         = r_state;

`ifdef MC_CTRL_PERF_EN
    logic [PERF_W-1:0] r_instr_count;
    logic [PERF_W-1:0] r_cycle_count;
    logic              w_complete;

    assign w_complete = (r_state == S_MEM_WB) || (r_state == S_MEM_WR) || (r_state == S_R_WB) ||
                        (r_state == S_BEQ)    || (r_state == S_I_WB)   || (r_state == S_JUMP) ||
                        (r_state == S_JAL)    || (r_state == S_JR);

    // Free-running cycle counter and retired-instruction counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycle_count <= {PERF_W{1'b0}};
            r_instr_count <= {PERF_W{1'b0}};
        end else begin
            r_cycle_count <= r_cycle_count + {{(PERF_W-1){1'b0}}, 1'b1};
            r_instr_count <= w_complete ? (r_instr_count + {{(PERF_W-1){1'b0}}, 1'b1})
                                        : r_instr_count;
        end
    end

    assign instr_count = r_instr_count;
    assign cycle_count = r_cycle_count;
`endif
endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: directed instructions push per-cycle expected
// state/control words; a negedge monitor pops and compares them.
module tb_mc_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       reg_dst, reg_dst2, data_write, mem_to_reg, reg_write, alu_src_a, illegal;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_ctrl;
    logic [3:0] state;
`ifdef MC_CTRL_PERF_EN
    logic [31:0] instr_count, cycle_count, ic0, cc0;
`endif

    mc_ctrl #(.PERF_W(32)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_dst(reg_dst), .reg_dst2(reg_dst2), .data_write(data_write),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl), .pc_src(pc_src), .illegal(illegal),
`ifdef MC_CTRL_PERF_EN
        .instr_count(instr_count), .cycle_count(cycle_count),
`endif
        .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  st;
        logic        ill;
        logic [18:0] ctl;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    logic pend_ill = 1'b0;

    // Control word: pw pwc iod mr mw irw | rd rd2 dw m2r rw asa | asb | alu | psrc
    function automatic logic [18:0] ctl_of(input logic [3:0] st, input logic [2:0] alu);
        logic [18:0] c;
        case (st)
            4'd0:  c = 19'b100101_000000_01_010_00;
            4'd1:  c = 19'b000000_000000_11_010_00;
            4'd2:  c = 19'b000000_000001_10_010_00;
            4'd3:  c = 19'b001100_000000_00_010_00;
            4'd4:  c = 19'b000000_000110_00_010_00;
            4'd5:  c = 19'b001010_000000_00_010_00;
            4'd6:  c = 19'b000000_000001_00_010_00;
            4'd7:  c = 19'b000000_100010_00_010_00;
            4'd8:  c = 19'b010000_000001_00_110_01;
            4'd9:  c = 19'b000000_000001_10_010_00;
            4'd10: c = 19'b000000_000010_00_010_00;
            4'd11: c = 19'b100000_000000_00_010_10;
            4'd12: c = 19'b100000_011010_00_010_10;
            4'd13: c = 19'b100000_000000_00_010_11;
            default: c = 19'b000000_000000_00_010_00;
        endcase
        if (st == 4'd6 || st == 4'd9) c[4:2] = alu;
        return c;
    endfunction

    task automatic push(input logic [3:0] st, input logic [2:0] alu, input logic ill, input logic in_rst);
        exp_t e;
        e.st  = st;
        e.ill = ill;
        e.ctl = ctl_of(st, alu);
        if (in_rst) e.ctl = e.ctl & ~19'b110111_000010_00_000_00;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb_q.size() != 0) begin
            n_vec++; n_err++;
            $display("FAIL drain_timeout: %0d expected vectors left, want 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    // seq holds up to five state numbers, first state in the top nibble.
    task automatic run(input logic [5:0] opc, input logic [5:0] fn, input logic z,
                       input logic [19:0] seq, input int n, input logic [2:0] alu, input logic ends_ill);
        opcode = opc; funct = fn; zero = z;
        for (int i = 0; i < n; i++)
            push(seq[19-4*i -: 4], alu, (i == 0) ? pend_ill : 1'b0, 1'b0);
        pend_ill = ends_ill;
        drain();
    endtask

    // Monitor: compare every cycle for which an expectation is queued.
    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            exp_t e;
            logic [18:0] got;
            e   = sb_q.pop_front();
            got = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                   reg_dst, reg_dst2, data_write, mem_to_reg, reg_write, alu_src_a,
                   alu_src_b, alu_ctrl, pc_src};
            n_vec++;
            if (state !== e.st || illegal !== e.ill || got !== e.ctl) begin
                n_err++;
                $display("FAIL vec%0d: got state=%0d illegal=%b ctl=%b, want state=%0d illegal=%b ctl=%b",
                         n_vec, state, illegal, got, e.st, e.ill, e.ctl);
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        run(6'b100011, 6'b000000, 1'b0, 20'h01234, 5, 3'b010, 1'b0);  // lw
        run(6'b101011, 6'b000000, 1'b0, 20'h01250, 4, 3'b010, 1'b0);  // sw
        run(6'b000000, 6'b100000, 1'b0, 20'h01670, 4, 3'b010, 1'b0);  // add
        run(6'b000000, 6'b100010, 1'b0, 20'h01670, 4, 3'b110, 1'b0);  // sub
        run(6'b000000, 6'b100100, 1'b0, 20'h01670, 4, 3'b000, 1'b0);  // and
        run(6'b000000, 6'b100101, 1'b0, 20'h01670, 4, 3'b001, 1'b0);  // or
        run(6'b000000, 6'b101010, 1'b0, 20'h01670, 4, 3'b111, 1'b0);  // slt
        run(6'b000100, 6'b000000, 1'b0, 20'h01800, 3, 3'b010, 1'b0);  // beq, not taken
        run(6'b000100, 6'b000000, 1'b1, 20'h01800, 3, 3'b010, 1'b0);  // beq, taken
        run(6'b001000, 6'b000000, 1'b0, 20'h019A0, 4, 3'b010, 1'b0);  // addi
        run(6'b001010, 6'b000000, 1'b0, 20'h019A0, 4, 3'b111, 1'b0);  // slti
        run(6'b000010, 6'b000000, 1'b0, 20'h01B00, 3, 3'b010, 1'b0);  // j
        run(6'b000011, 6'b000000, 1'b0, 20'h01C00, 3, 3'b010, 1'b0);  // jal
        run(6'b000000, 6'b001000, 1'b0, 20'h01D00, 3, 3'b010, 1'b0);  // jr

        // Reset held two cycles starting in MEM_RD of a lw.
        opcode = 6'b100011; funct = 6'b000000;
        push(4'd0, 3'b010, pend_ill, 1'b0);
        push(4'd1, 3'b010, 1'b0, 1'b0);
        push(4'd2, 3'b010, 1'b0, 1'b0);
        push(4'd3, 3'b010, 1'b0, 1'b1);
        push(4'd0, 3'b010, 1'b0, 1'b1);
        pend_ill = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        drain();

`ifdef MC_CTRL_PERF_EN
        ic0 = instr_count; cc0 = cycle_count;
`endif
        run(6'b111111, 6'b000000, 1'b0, 20'h01000, 2, 3'b010, 1'b1);  // illegal opcode
`ifdef MC_CTRL_PERF_EN
        n_vec++;
        if (instr_count !== ic0 || cycle_count !== cc0 + 32'd2) begin
            n_err++;
            $display("FAIL perf_illegal: got instr=%0d cycle=%0d, want instr=%0d cycle=%0d",
                     instr_count, cycle_count, ic0, cc0 + 32'd2);
        end
`endif
        run(6'b000000, 6'b000111, 1'b0, 20'h01600, 3, 3'b010, 1'b1);  // illegal funct
        run(6'b100011, 6'b000000, 1'b0, 20'h01234, 5, 3'b010, 1'b0);  // lw after illegal

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
